// File: rtl/execute_cycle_pkg.sv
// rtl/execute_cycle_pkg.sv - shared encodings for the execute stage, hazard unit and decoder
package execute_cycle_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLL  = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic w_lt;
      logic w_ltu;
      w_lt  = $signed(a) < $signed(b);
      w_ltu = a < b;
      case (f3)
         BR_EQ:   return a == b;
         BR_NE:   return a != b;
         BR_LT:   return w_lt;
         BR_GE:   return !w_lt;
         BR_LTU:  return w_ltu;
         BR_GEU:  return !w_ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// rtl/execute_cycle_alu.sv - 32-bit integer ALU used by the execute stage
module alu
   import execute_cycle_pkg::*;
(
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [2:0]  ALUControl,
   output logic [31:0] Result,
   output logic        Zero
);

   always_comb begin
      Result = 32'h0;
      case (ALUControl)
         ALU_ADD:  Result = SrcA + SrcB;
         ALU_SUB:  Result = SrcA - SrcB;
         ALU_AND:  Result = SrcA & SrcB;
         ALU_OR:   Result = SrcA | SrcB;
         ALU_XOR:  Result = SrcA ^ SrcB;
         ALU_SLT:  Result = {31'h0, $signed(SrcA) < $signed(SrcB)};
         ALU_SLTU: Result = {31'h0, SrcA < SrcB};
         ALU_SLL:  Result = SrcA << SrcB[4:0];
         default:  Result = 32'h0;
      endcase
   end

   assign Zero = (Result == 32'h0);

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - execute stage: forwarding, ALU, branch resolve and EX/MEM register
module execute_cycle
   import execute_cycle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        BranchE,
   input  logic        JumpE,
   input  logic        JalrE,
   input  logic        ALUSrcE,
   input  logic [1:0]  ResultSrcE,
   input  logic [2:0]  ALUControlE,
   input  logic [2:0]  funct3E,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   input  logic [31:0] Imm_Ext_E,
   input  logic [31:0] PCE,
   input  logic [31:0] PCPlus4E,
   input  logic [4:0]  RD_E,
   input  logic [1:0]  ForwardA_E,
   input  logic [1:0]  ForwardB_E,
   input  logic [31:0] ResultW,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic [1:0]  ResultSrcM,
   output logic [4:0]  RD_M,
   output logic [31:0] PCPlus4M,
   output logic [31:0] WriteDataM,
   output logic [31:0] ALU_ResultM
);

   logic [31:0] w_src_a;
   logic [31:0] w_write_data;
   logic [31:0] w_src_b;
   logic [31:0] w_alu_result;
   logic        w_alu_zero;
   logic [31:0] w_jalr_sum;

   logic        r_reg_write;
   logic        r_mem_write;
   logic [1:0]  r_result_src;
   logic [4:0]  r_rd;
   logic [31:0] r_pc_plus4;
   logic [31:0] r_write_data;
   logic [31:0] r_alu_result;

   // MEM-stage forwarding reads the registered result, i.e. the previous instruction
   always_comb begin
      w_src_a = RD1_E;
      case (ForwardA_E)
         FWD_WB:  w_src_a = ResultW;
         FWD_MEM: w_src_a = r_alu_result;
         default: w_src_a = RD1_E;
      endcase
   end

   always_comb begin
      w_write_data = RD2_E;
      case (ForwardB_E)
         FWD_WB:  w_write_data = ResultW;
         FWD_MEM: w_write_data = r_alu_result;
         default: w_write_data = RD2_E;
      endcase
   end

   assign w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;

   alu u_alu (
      .SrcA       (w_src_a),
      .SrcB       (w_src_b),
      .ALUControl (ALUControlE),
      .Result     (w_alu_result),
      .Zero       (w_alu_zero)
   );

   assign w_jalr_sum = w_src_a + Imm_Ext_E;
   assign PCSrcE     = JumpE | (BranchE & branch_taken(funct3E, w_src_a, w_write_data));
   assign PCTargetE  = JalrE ? {w_jalr_sum[31:1], 1'b0} : (PCE + Imm_Ext_E);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= 2'b00;
         r_rd         <= 5'h00;
         r_pc_plus4   <= 32'h0;
         r_write_data <= 32'h0;
         r_alu_result <= 32'h0;
      end else begin
         r_reg_write  <= RegWriteE;
         r_mem_write  <= MemWriteE;
         r_result_src <= ResultSrcE;
         r_rd         <= RD_E;
         r_pc_plus4   <= PCPlus4E;
         r_write_data <= w_write_data;
         r_alu_result <= w_alu_result;
      end
   end

   assign RegWriteM   = r_reg_write;
   assign MemWriteM   = r_mem_write;
   assign ResultSrcM  = r_result_src;
   assign RD_M        = r_rd;
   assign PCPlus4M    = r_pc_plus4;
   assign WriteDataM  = r_write_data;
   assign ALU_ResultM = r_alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - self-checking bench for execute_cycle against a behavioural model
module tb_execute_cycle;

   logic        clk;
   logic        rst;
   logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE, funct3E;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

   int n_checks = 0;
   int n_fail   = 0;

   // Model of the EX/MEM register contents
   logic        e_rw, e_mw;
   logic [1:0]  e_rs;
   logic [4:0]  e_rd;
   logic [31:0] e_pc4, e_wd, e_alu;

   execute_cycle dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
      .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
      .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .funct3E(funct3E),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
      .ForwardB_E(ForwardB_E), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
      .ALU_ResultM(ALU_ResultM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'd1) return ResultW;
      if (sel == 2'd2) return e_alu;
      return rf;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: return (a < b) ? 32'd1 : 32'd0;
         default: return a << sh;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      e_rw = 0; e_mw = 0; e_rs = 0; e_rd = 0; e_pc4 = 0; e_wd = 0; e_alu = 0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".RegWriteM"},   {31'h0, RegWriteM},  {31'h0, e_rw});
      chk({tag, ".MemWriteM"},   {31'h0, MemWriteM},  {31'h0, e_mw});
      chk({tag, ".ResultSrcM"},  {30'h0, ResultSrcM}, {30'h0, e_rs});
      chk({tag, ".RD_M"},        {27'h0, RD_M},       {27'h0, e_rd});
      chk({tag, ".PCPlus4M"},    PCPlus4M,            e_pc4);
      chk({tag, ".WriteDataM"},  WriteDataM,          e_wd);
      chk({tag, ".ALU_ResultM"}, ALU_ResultM,         e_alu);
   endtask

   // Checks the combinational outputs, clocks one edge, then checks the register
   task automatic step(input string tag);
      logic [31:0] a, wd, b, tgt, alu_v;
      logic        pcsrc;
      #1;
      a     = fwd(ForwardA_E, RD1_E);
      wd    = fwd(ForwardB_E, RD2_E);
      b     = ALUSrcE ? Imm_Ext_E : wd;
      alu_v = ref_alu(ALUControlE, a, b);
      pcsrc = JumpE || (BranchE && ref_taken(funct3E, a, wd));
      tgt   = JalrE ? ((a + Imm_Ext_E) & ~32'h1) : (PCE + Imm_Ext_E);
      chk({tag, ".PCSrcE"},    {31'h0, PCSrcE}, {31'h0, pcsrc});
      chk({tag, ".PCTargetE"}, PCTargetE, tgt);
      @(posedge clk);
      #1;
      e_rw = RegWriteE; e_mw = MemWriteE; e_rs = ResultSrcE; e_rd = RD_E;
      e_pc4 = PCPlus4E; e_wd = wd; e_alu = alu_v;
      check_regs(tag);
   endtask

   task automatic rand_inputs();
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); BranchE = 1'($urandom);
      JumpE = 1'($urandom); JalrE = 1'($urandom); ALUSrcE = 1'($urandom);
      ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom); funct3E = 3'($urandom);
      RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; PCE = $urandom;
      PCPlus4E = $urandom; RD_E = 5'($urandom); ForwardA_E = 2'($urandom);
      ForwardB_E = 2'($urandom); ResultW = $urandom;
      if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
   endtask

   task automatic quiet_inputs();
      RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; JalrE = 0; ALUSrcE = 0;
      ResultSrcE = 0; ALUControlE = 0; funct3E = 3'b010; RD1_E = 0; RD2_E = 0;
      Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
      ResultW = 0;
   endtask

   initial begin
      rst = 1'b0;
      rand_inputs();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_regs("rst_async");
      repeat (2) begin
         rand_inputs();
         @(posedge clk);
         #1;
         check_regs("rst_held");
      end
      #2 rst = 1'b0;

      quiet_inputs();
      RD1_E = 32'd5; RD2_E = 32'd7;
      step("add5_7");
      chk("add5_7.const", ALU_ResultM, 32'd12);

      RD1_E = 32'h8; RD2_E = 32'h8;
      step("fwd_seed");
      chk("fwd_seed.const", ALU_ResultM, 32'h10);
      ForwardA_E = 2'b10; RD1_E = 32'hDEAD; Imm_Ext_E = 32'd4; ALUSrcE = 1'b1;
      step("fwd_mem");
      chk("fwd_mem.const", ALU_ResultM, 32'h14);
      ForwardA_E = 2'b01; ResultW = 32'h100;
      step("fwd_wb");
      chk("fwd_wb.const", ALU_ResultM, 32'h104);

      quiet_inputs();
      BranchE = 1'b1; funct3E = 3'b100; RD1_E = 32'hFFFFFFFF; RD2_E = 32'd1;
      #1 chk("blt.const", {31'h0, PCSrcE}, 32'd1);
      step("blt");
      funct3E = 3'b110;
      #1 chk("bltu.const", {31'h0, PCSrcE}, 32'd0);
      step("bltu");

      quiet_inputs();
      JalrE = 1'b1; JumpE = 1'b1; RD1_E = 32'h1001; Imm_Ext_E = 32'h2;
      #1 chk("jalr_tgt.const", PCTargetE, 32'h1002);
      chk("jalr_src.const", {31'h0, PCSrcE}, 32'd1);
      step("jalr");
      quiet_inputs();
      PCE = 32'hFFFFFFFC; Imm_Ext_E = 32'd8;
      #1 chk("pcwrap.const", PCTargetE, 32'h4);
      step("pcwrap");

      quiet_inputs();
      ALUControlE = 3'b001; RD1_E = 0; RD2_E = 32'd1;
      step("sub0_1");
      chk("sub0_1.const", ALU_ResultM, 32'hFFFFFFFF);
      ALUControlE = 3'b111; RD1_E = 32'd1; ALUSrcE = 1'b1; Imm_Ext_E = 32'd31;
      step("sll31");
      chk("sll31.const", ALU_ResultM, 32'h80000000);
      ALUControlE = 3'b101; RD1_E = 32'h80000000; ALUSrcE = 1'b0; RD2_E = 0;
      step("slt_neg");
      chk("slt_neg.const", ALU_ResultM, 32'd1);

      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         step("rand");
      end

      quiet_inputs();
      MemWriteE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd9;
      step("mw_pre");
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("midrst.MemWriteM", {31'h0, MemWriteM}, 32'd0);
      check_regs("midrst");
      repeat (2) begin
         @(posedge clk);
         #1 chk("midrst_hold.MemWriteM", {31'h0, MemWriteM}, 32'd0);
      end
      #2 rst = 1'b0;
      #1 chk("midrst_rel.MemWriteM", {31'h0, MemWriteM}, 32'd0);
      step("post_rst");
      chk("post_rst.MemWriteM", {31'h0, MemWriteM}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; clk and rst are the only clock/reset ports.
REQ-002 clk  in  1  rising-edge clock for the EX/MEM pipeline register.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE  in  1 each  control bits from ID/EX.
REQ-005 ResultSrcE  in  2  writeback select, passed through unchanged.
REQ-006 ALUControlE  in  3  ALU operation code.
REQ-007 funct3E  in  3  branch condition select.
REQ-008 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  register operands, immediate, PC, PC+4.
REQ-009 RD_E  in  5  destination register index.
REQ-010 ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit.
REQ-011 ResultW  in  32  writeback-stage result, used for forwarding.
REQ-012 PCSrcE  out  1  redirect fetch (combinational).
REQ-013 PCTargetE  out  32  redirect target (combinational).
REQ-014 RegWriteM, MemWriteM  out  1 each; ResultSrcM  out  2; RD_M  out  5; PCPlus4M, WriteDataM, ALU_ResultM  out  32 each; all are registered EX/MEM outputs.

Function
REQ-015 Forward select SrcA: 00 -> RD1_E, 01 -> ResultW, 10 -> ALU_ResultM (own registered output), 11 -> RD1_E.
REQ-016 Forwarded rs2 value (WriteDataE) uses the same encoding on RD2_E with ForwardB_E.
REQ-017 SrcB = ALUSrcE ? Imm_Ext_E : WriteDataE.
REQ-018 ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sltu, 111 sll by SrcB[4:0].
REQ-019 Arithmetic is modulo 2^32, with no overflow flag; slt and sltu return 32'h1 or 32'h0.
REQ-020 Branch compare uses SrcA vs WriteDataE, independent of the ALU.
REQ-021 funct3E branch codes: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010 and 011 mean not taken.
REQ-022 PCSrcE = JumpE | (BranchE & taken).
REQ-023 PCTargetE = JalrE ? ((SrcA + Imm_Ext_E) & ~32'h1) : (PCE + Imm_Ext_E), wrapping modulo 2^32.
REQ-024 On every rising clk edge with rst low, the EX/MEM register SHALL capture RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, WriteDataE and the ALU result. Latency is exactly 1 cycle; there is no stall or enable.
REQ-025 ALU_ResultM forwarding SHALL see the value registered in the previous cycle, so back-to-back dependent instructions forward correctly.
REQ-026 PCSrcE and PCTargetE SHALL be purely combinational, with zero-cycle latency; flushing younger stages belongs to the hazard unit.

Reset
REQ-027 While rst is high, all registered outputs SHALL be 0 (RegWriteM=0, MemWriteM=0, ResultSrcM=2'b00, RD_M=5'h00, 32-bit outputs=32'h0), asynchronously and independent of clk.
REQ-028 A reset asserted mid-operation SHALL discard the in-flight instruction; no memory write or register write is issued for it.
REQ-029 On the first edge after rst deasserts, the register SHALL capture normally.

Structure
REQ-030 ALU opcodes, forward-select encodings and branch funct3 encodings SHALL be localparams in a shared package, imported by the hazard unit and the decoder.
REQ-031 The ALU SHALL be a sub-module named alu (SrcA, SrcB, ALUControl -> Result, Zero); forwarding, branch and the register stay in execute_cycle.

Verification
REQ-032 Reset: rst=1 with random inputs -> all M outputs 0; release rst, then one edge with add 5+7 -> ALU_ResultM=12.
REQ-033 Forwarding: cycle 1 add producing 32'h10; cycle 2 ForwardA_E=10 with RD1_E=32'hDEAD, Imm=4, ALUSrcE=1 -> ALU_ResultM=32'h14; ForwardA_E=01 with ResultW=32'h100 -> 32'h104.
REQ-034 Branch: BranchE=1, funct3E=100, SrcA=32'hFFFFFFFF, rs2=1 -> PCSrcE=1; the same operands with funct3E=110 -> PCSrcE=0.
REQ-035 JALR: JalrE=JumpE=1, SrcA=32'h1001, Imm=32'h2 -> PCTargetE=32'h1002, PCSrcE=1; PCE=32'hFFFFFFFC, Imm=8, JalrE=0 -> PCTargetE=32'h4.
REQ-036 ALU edges: sub 0-1 -> 32'hFFFFFFFF; sll 1 by 31 -> 32'h80000000; slt 32'h80000000 < 0 -> 1.
REQ-037 Mid-operation reset: assert rst asynchronously between edges while MemWriteE=1 -> MemWriteM drops to 0 immediately and stays 0 until the first edge after release.
